// File: rtl/julia_mem_writer.sv
// Collects finished pixel results from the Julia worker array into a FIFO and
// drains them to frame-buffer memory, counting writes per frame.
module julia_mem_writer #(
  parameter int NUM_WORKERS  = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WORKERS-1:0]      jw_done,
  input  logic [32*NUM_WORKERS-1:0]   jw_address,
  input  logic [32*NUM_WORKERS-1:0]   jw_color,
  output logic [NUM_WORKERS-1:0]      mc_busy,
  output logic [31:0]                 avm_address,
  output logic [31:0]                 avm_writedata,
  output logic                        avm_write,
  input  logic                        avm_waitrequest,
  output logic [18:0]                 pixel_count,
  output logic                        frame_done
);

  localparam int PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  // Handshake: a worker holds jw_done with its result until mc_busy drops for
  // one cycle (the ack); during that cycle the worker is masked from arbitration.
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_WORKERS-1:0] busy_q, busy_d;
  logic [NUM_WORKERS-1:0] eligible;
  logic                   grant_vld;
  logic [PW-1:0]          grant_idx;
  int                     search_idx;

  logic [31:0]            addr_mem_q  [FIFO_DEPTH];
  logic [31:0]            color_mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q, count_d;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop;

  logic [18:0]            pix_q, pix_d;
  logic                   frame_done_q, frame_done_d;

  assign eligible   = jw_done & busy_q;
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = 0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      search_idx = (int'(rr_ptr_q) + k) % NUM_WORKERS;
      if (!grant_vld && eligible[search_idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(search_idx);
      end
    end
  end

  // No full-bypass: occupancy at the start of the cycle alone gates the push.
  assign push = grant_vld && !fifo_full;
  assign pop  = !fifo_empty && !avm_waitrequest;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    busy_d   = '1;
    if (push) begin
      rr_ptr_d          = PW'((int'(grant_idx) + 1) % NUM_WORKERS);
      busy_d[grant_idx] = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pix_d        = pix_q;
    frame_done_d = 1'b0;
    if (pop) begin
      if (pix_q == 19'(FRAME_PIXELS - 1)) begin
        pix_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      busy_q       <= '1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pix_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
      pix_q        <= pix_d;
      frame_done_q <= frame_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_mem_q[wr_ptr_q]  <= jw_address[int'(grant_idx)*32 +: 32];
      color_mem_q[wr_ptr_q] <= jw_color[int'(grant_idx)*32 +: 32];
    end
  end

  assign mc_busy       = busy_q;
  assign avm_write     = !fifo_empty;
  assign avm_address   = fifo_empty ? 32'd0 : addr_mem_q[rd_ptr_q];
  assign avm_writedata = fifo_empty ? 32'd0 : color_mem_q[rd_ptr_q];
  assign pixel_count   = pix_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_julia_mem_writer.sv
// Bench for julia_mem_writer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_julia_mem_writer;

  localparam int NW = 10;
  localparam int FD = 8;
  localparam int FP = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NW-1:0]     jw_done = '0;
  logic [32*NW-1:0]  jw_address = '0;
  logic [32*NW-1:0]  jw_color = '0;
  logic [NW-1:0]     mc_busy;
  logic [31:0]       avm_address, avm_writedata;
  logic              avm_write;
  logic              avm_waitrequest = 1'b0;
  logic [18:0]       pixel_count;
  logic              frame_done;

  julia_mem_writer #(.NUM_WORKERS(NW), .FIFO_DEPTH(FD), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst(rst), .jw_done(jw_done), .jw_address(jw_address),
    .jw_color(jw_color), .mc_busy(mc_busy), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_write(avm_write),
    .avm_waitrequest(avm_waitrequest), .pixel_count(pixel_count),
    .frame_done(frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [63:0]   exp_q[$];
  logic [NW-1:0] m_busy = '1;
  int            m_ptr = 0;
  int            m_pc = 0;
  logic          m_fd = 1'b0;
  logic          model_ok = 1'b0;
  int            cyc = 0;

  always @(posedge clk) begin
    int  g;
    int  idx;
    bit  full;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_ptr    = 0;
      m_busy   = '1;
      m_pc     = 0;
      m_fd     = 1'b0;
      model_ok = 1'b1;
    end else begin
      full = (exp_q.size() == FD);
      g = -1;
      for (int k = 0; k < NW; k++) begin
        idx = (m_ptr + k) % NW;
        if (g < 0 && jw_done[idx] && m_busy[idx]) g = idx;
      end
      m_fd = 1'b0;
      if (exp_q.size() > 0 && !avm_waitrequest) begin
        void'(exp_q.pop_front());
        if (m_pc == FP - 1) begin
          m_pc = 0;
          m_fd = 1'b1;
        end else begin
          m_pc++;
        end
      end
      m_busy = '1;
      if (g >= 0 && !full) begin
        exp_q.push_back({jw_address[32*g +: 32], jw_color[32*g +: 32]});
        m_busy[g] = 1'b0;
        m_ptr = (g + 1) % NW;
      end
    end
  end

  // ---------------- workers ----------------
  // Each worker presents one offered result at a time and drops jw_done on ack,
  // unless asked to keep holding it for extra acks.
  int          offer_seq [NW];
  int          served_seq[NW];
  int          hold_req  [NW];
  int          hold_used [NW];
  logic [31:0] w_addr[NW];
  logic [31:0] w_col [NW];
  int          ack_who[$];
  int          ack_cyc[$];

  initial begin
    for (int i = 0; i < NW; i++) begin
      offer_seq[i] = 0;
      hold_req[i]  = 0;
      w_addr[i]    = '0;
      w_col[i]     = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NW; i++) begin
      if (jw_done[i] && !mc_busy[i]) begin
        ack_who.push_back(i);
        ack_cyc.push_back(cyc);
        if (hold_used[i] < hold_req[i]) begin
          hold_used[i]++;
        end else begin
          jw_done[i]    = 1'b0;
          served_seq[i] = served_seq[i] + 1;
        end
      end else if (!jw_done[i] && offer_seq[i] != served_seq[i]) begin
        jw_done[i]           = 1'b1;
        jw_address[32*i +: 32] = w_addr[i];
        jw_color[32*i +: 32]   = w_col[i];
      end
    end
  end

  initial begin
    for (int i = 0; i < NW; i++) begin
      served_seq[i] = 0;
      hold_used[i]  = 0;
    end
  end

  // ---------------- memory-side monitor ----------------
  logic [63:0] wr_log[$];
  int          fd_cnt = 0;
  int          fd_at = 0;
  int          fd_pc = 0;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      fd_at = wr_log.size();
      fd_pc = int'(pixel_count);
    end
    if (avm_write && !avm_waitrequest) wr_log.push_back({avm_address, avm_writedata});
  end

  // ---------------- scoreboard / compare ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    if (model_ok) begin
      chk("mc_busy", 64'(mc_busy), 64'(m_busy));
      chk("avm_write", 64'(avm_write), 64'(exp_q.size() != 0));
      chk("avm_address", 64'(avm_address), exp_q.size() != 0 ? 64'(exp_q[0][63:32]) : 64'd0);
      chk("avm_writedata", 64'(avm_writedata), exp_q.size() != 0 ? 64'(exp_q[0][31:0]) : 64'd0);
      chk("pixel_count", 64'(pixel_count), 64'(m_pc));
      chk("frame_done", 64'(frame_done), 64'(m_fd));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cmp_all();
    end
  endtask

  task automatic offer(input int i, input logic [31:0] a, input logic [31:0] c);
    w_addr[i]    = a;
    w_col[i]     = c;
    offer_seq[i] = offer_seq[i] + 1;
  endtask

  function automatic bit workers_busy();
    for (int i = 0; i < NW; i++)
      if (offer_seq[i] != served_seq[i] || jw_done[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((workers_busy() || avm_write) && n < 300) begin
      step(1);
      n++;
    end
    chk(nm, 64'(n >= 300), 64'd0);
    step(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  int ack_base, wr_base, fd_base, n;

  initial begin
    // reset state
    step(2);
    chk("reset avm_write", 64'(avm_write), 64'd0);
    chk("reset avm_address", 64'(avm_address), 64'd0);
    chk("reset pixel_count", 64'(pixel_count), 64'd0);
    chk("reset mc_busy", 64'(mc_busy), 64'(10'h3FF));
    rst = 1'b0;

    // single result, idle memory
    ack_base = ack_who.size(); wr_base = wr_log.size();
    offer(0, 32'h100, 32'hFF0000);
    n = 0;
    while (!avm_write && n < 20) begin step(1); n++; end
    chk("single timeout", 64'(n >= 20), 64'd0);
    chk("single addr", 64'(avm_address), 64'h100);
    chk("single data", 64'(avm_writedata), 64'hFF0000);
    chk("single busy low", 64'(mc_busy[0]), 64'd0);
    step(1);
    chk("single busy back", 64'(mc_busy[0]), 64'd1);
    chk("single pixel_count", 64'(pixel_count), 64'd1);
    wait_idle("single idle");

    // round robin among four simultaneous workers
    do_reset();
    ack_base = ack_who.size(); wr_base = wr_log.size();
    for (int i = 0; i < 4; i++) offer(i, 32'(4*i), 32'(i + 1));
    wait_idle("rr idle");
    chk("rr ack count", 64'(ack_who.size() - ack_base), 64'd4);
    chk("rr write count", 64'(wr_log.size() - wr_base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr ack order", 64'(ack_who[ack_base + i]), 64'(i));
      chk("rr ack consecutive", 64'(ack_cyc[ack_base + i] - ack_cyc[ack_base]), 64'(i));
      chk("rr write addr", 64'(wr_log[wr_base + i][63:32]), 64'(4*i));
    end

    // back-pressure until full, then release
    do_reset();
    ack_base = ack_who.size(); wr_base = wr_log.size(); fd_base = fd_cnt;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < NW; i++) offer(i, 32'h1000 + 32'(4*i), 32'hC000 + 32'(i));
    step(16);
    chk("bp captured", 64'(ack_who.size() - ack_base), 64'd8);
    chk("bp worker8 busy", 64'(mc_busy[8]), 64'd1);
    chk("bp worker9 busy", 64'(mc_busy[9]), 64'd1);
    chk("bp worker9 done held", 64'(jw_done[9]), 64'd1);
    chk("bp head addr", 64'(avm_address), 64'h1000);
    chk("bp head data", 64'(avm_writedata), 64'hC000);
    avm_waitrequest = 1'b0;
    wait_idle("bp idle");
    chk("bp write count", 64'(wr_log.size() - wr_base), 64'd10);
    for (int i = 0; i < NW; i++)
      chk("bp write order", wr_log[wr_base + i], {32'h1000 + 32'(4*i), 32'hC000 + 32'(i)});
    chk("bp pixel_count", 64'(pixel_count), 64'd0);
    chk("bp frame pulses", 64'(fd_cnt - fd_base), 64'd2);

    // frame wrap with seven results
    do_reset();
    wr_base = wr_log.size(); fd_base = fd_cnt;
    for (int i = 0; i < 7; i++) offer(i, 32'h2000 + 32'(4*i), 32'(i));
    wait_idle("frame idle");
    chk("frame pulses", 64'(fd_cnt - fd_base), 64'd1);
    chk("frame pulse on 5th", 64'(fd_at - wr_base), 64'd5);
    chk("frame count at pulse", 64'(fd_pc), 64'd0);
    chk("frame count end", 64'(pixel_count), 64'd2);
    chk("frame writes", 64'(wr_log.size() - wr_base), 64'd7);

    // reset mid-operation (pixel_count is 2 coming in)
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) offer(i, 32'h3100 + 32'(4*i), 32'(i));
    step(8);
    chk("midrst buffered", 64'(avm_write), 64'd1);
    offer(3, 32'h3000, 32'h3333);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wr_base = wr_log.size();
    chk("midrst avm_write", 64'(avm_write), 64'd0);
    chk("midrst pixel_count", 64'(pixel_count), 64'd0);
    chk("midrst mc_busy", 64'(mc_busy), 64'(10'h3FF));
    step(1);
    chk("midrst recapture", 64'(mc_busy[3]), 64'd0);
    chk("midrst head", 64'(avm_address), 64'h3000);
    avm_waitrequest = 1'b0;
    wait_idle("midrst idle");
    chk("midrst writes", 64'(wr_log.size() - wr_base), 64'd1);
    if (wr_log.size() > wr_base) chk("midrst write", wr_log[wr_base], {32'h3000, 32'h3333});

    // worker keeps jw_done through its ack cycle
    do_reset();
    ack_base = ack_who.size(); wr_base = wr_log.size();
    hold_req[5] = 1;
    offer(5, 32'h5000, 32'h55);
    wait_idle("hold idle");
    chk("hold ack count", 64'(ack_who.size() - ack_base), 64'd2);
    if (ack_who.size() - ack_base == 2)
      chk("hold ack spacing", 64'(ack_cyc[ack_base + 1] - ack_cyc[ack_base]), 64'd2);
    chk("hold writes", 64'(wr_log.size() - wr_base), 64'd2);
    chk("hold pixel_count", 64'(pixel_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
